adder: RTL and testbench

//  One-bit full adder: f = sum and cplus = carry-out of a + b + carry-in.
//  Sum and carry are combinational with zero latency. With ser = 0 and
//  en = 0, the block is a pure full adder.

---
 rtl/adder_if.sv | 24 ++
 rtl/adder.sv | 44 ++++
 tb/tb_adder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adder_if.sv
// adder_if: groups the data and control bits of the adder leaf cell.
//   master : drives a, b, c, ser, en; observes f, cplus, f_q, cplus_q
//   slave  : the adder itself
interface adder_if;
    logic a;        // addend bit
    logic b;        // augend bit
    logic c;        // external carry-in (used when ser = 0)
    logic ser;      // 1 = carry-in from internal carry register
    logic en;       // register update enable
    logic f;        // combinational sum
    logic cplus;    // combinational carry-out
    logic f_q;      // registered sum
    logic cplus_q;  // registered carry-out

    modport master (
        output a, b, c, ser, en,
        input  f, cplus, f_q, cplus_q
    );

    modport slave (
        input  a, b, c, ser, en,
        output f, cplus, f_q, cplus_q
    );
endinterface

// File: rtl/adder.sv
// adder: one-bit full adder leaf cell with optional bit-serial operation.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears f_q, cplus_q, carry register)
//   bus  : adder_if.slave
//          a, b, c, ser, en in; f, cplus (combinational), f_q, cplus_q out
// With ser = 1 the carry-in comes from the internal carry register, so a
// multi-bit word can be added LSB first, one bit per enabled clock.
module adder (
    input  logic    clk,
    input  logic    rst,
    adder_if.slave  bus
);

    logic cy_q;
    logic cin;
    logic sum;
    logic carry;
    logic f_q;
    logic cplus_q;

    always_comb begin
        cin   = bus.ser ? cy_q : bus.c;
        sum   = bus.a ^ bus.b ^ cin;
        carry = (bus.a & bus.b) | (bus.a & cin) | (bus.b & cin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q     <= 1'b0;
            cplus_q <= 1'b0;
            cy_q    <= 1'b0;
        end else if (bus.en) begin
            f_q     <= sum;
            cplus_q <= carry;
            cy_q    <= carry;
        end
    end

    assign bus.f       = sum;
    assign bus.cplus   = carry;
    assign bus.f_q     = f_q;
    assign bus.cplus_q = cplus_q;

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed self-checking bench for the adder leaf cell.
// The internal carry register is observed through the combinational sum:
// with ser = 1 and a = b = 0, f equals the stored carry.
module tb_adder;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    adder_if bus ();

    adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // {a,b,c} -> {f,cplus}
    logic [2:0] tt_in  [8];
    logic [1:0] tt_out [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tt_in[0] = 3'b000; tt_out[0] = 2'b00;
        tt_in[1] = 3'b100; tt_out[1] = 2'b10;
        tt_in[2] = 3'b010; tt_out[2] = 2'b10;
        tt_in[3] = 3'b001; tt_out[3] = 2'b10;
        tt_in[4] = 3'b110; tt_out[4] = 2'b01;
        tt_in[5] = 3'b101; tt_out[5] = 2'b01;
        tt_in[6] = 3'b011; tt_out[6] = 2'b01;
        tt_in[7] = 3'b111; tt_out[7] = 2'b11;

        rst     = 1'b1;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.c   = 1'b0;
        bus.ser = 1'b0;
        bus.en  = 1'b0;
        #1;
        check("reset_regs", {bus.f_q, bus.cplus_q}, 2'b00);

        // Truth table, ser = 0, en = 0, reset held: combinational path only.
        for (int i = 0; i < 8; i++) begin
            {bus.a, bus.b, bus.c} = tt_in[i];
            #1;
            check($sformatf("truth_%b", tt_in[i]), {bus.f, bus.cplus}, tt_out[i]);
            #99;
        end

        // Registered path.
        @(negedge clk);
        rst = 1'b0;
        bus.ser = 1'b0; bus.en = 1'b1;
        {bus.a, bus.b, bus.c} = 3'b111;
        @(posedge clk); #1;
        check("reg_111", {bus.f_q, bus.cplus_q}, 2'b11);
        @(negedge clk);
        bus.en = 1'b0;
        {bus.a, bus.b, bus.c} = 3'b000;
        @(posedge clk); @(posedge clk); #1;
        check("reg_hold", {bus.f_q, bus.cplus_q}, 2'b11);
        // Carry register holds 1: visible via ser = 1, a = b = 0.
        bus.ser = 1'b1;
        #1;
        check("cy_hold_1", {bus.f, bus.cplus}, 2'b10);

        // Async reset between edges with cy_q = 1.
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst_regs", {bus.f_q, bus.cplus_q}, 2'b00);
        check("async_rst_cy", {bus.f, bus.cplus}, 2'b00);
        bus.a = 1'b1; bus.b = 1'b0;
        #1;
        check("rst_live_comb", {bus.f, bus.cplus}, 2'b10);

        // Serial 3 + 1, LSB first: {a,b} = 11, 10, 00.
        @(negedge clk);
        rst = 1'b0;
        bus.ser = 1'b1; bus.en = 1'b1;
        bus.a = 1'b1; bus.b = 1'b1;
        #1;
        check("ser_b0_comb", {bus.f, bus.cplus}, 2'b01);
        @(posedge clk); #1;
        check("ser_b0_reg", {bus.f_q, bus.cplus_q}, 2'b01);
        @(negedge clk);
        bus.a = 1'b1; bus.b = 1'b0;
        #1;
        check("ser_b1_comb", {bus.f, bus.cplus}, 2'b01);
        @(posedge clk); #1;
        check("ser_b1_reg", {bus.f_q, bus.cplus_q}, 2'b01);
        @(negedge clk);
        bus.a = 1'b0; bus.b = 1'b0;
        #1;
        check("ser_b2_comb", {bus.f, bus.cplus}, 2'b10);
        @(posedge clk); #1;
        check("ser_b2_reg", {bus.f_q, bus.cplus_q}, 2'b10);
        @(negedge clk);
        bus.en = 1'b0;
        #1;
        check("ser_end_cy0", {bus.f, bus.cplus}, 2'b00);

        // Reset release: first edge after release sees cin = 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ser = 1'b1; bus.en = 1'b1;
        bus.a = 1'b1; bus.b = 1'b1;
        #1;
        check("rel_comb", {bus.f, bus.cplus}, 2'b01);
        @(posedge clk); #1;
        check("rel_reg", {bus.f_q, bus.cplus_q}, 2'b01);
        bus.en = 1'b0;
        bus.a = 1'b0; bus.b = 1'b0;
        #1;
        check("rel_cy1", {bus.f, bus.cplus}, 2'b10);
        @(posedge clk); #1;
        check("rel_en0_hold", {bus.f_q, bus.cplus_q}, 2'b01);

        // ser = 0 ignores the stored carry.
        bus.ser = 1'b0; bus.c = 1'b0;
        #1;
        check("ser0_ignores_cy", {bus.f, bus.cplus}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
